// File: rtl/alu_vec_pkg.sv
// Shared types and constants for the ALU vector runner: FSM states, op codes,
// flag bit positions and the packed table entry.
package alu_vec_pkg;

  localparam int unsigned VEC_DATA_W = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam int unsigned FLG_INEXACT     = 0;
  localparam int unsigned FLG_UNDERFLOW   = 1;
  localparam int unsigned FLG_OVERFLOW    = 2;
  localparam int unsigned FLG_DIV_BY_ZERO = 3;
  localparam int unsigned FLG_INVALID     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_VALID,
    ST_CHECK,
    ST_WAIT_CLEAR,
    ST_DONE
  } state_e;

  // Data fields are stored at the widest supported width; narrower DATA_W
  // builds zero-extend on write and truncate on read.
  typedef struct packed {
    logic [VEC_DATA_W-1:0] op_a;
    logic [VEC_DATA_W-1:0] op_b;
    logic [2:0]            op_code;
    logic                  mode_fp;
    logic                  round_mode;
    logic [VEC_DATA_W-1:0] exp_result;
    logic [4:0]            exp_flags;
  } vec_entry_t;

endpackage

// File: rtl/alu_vector_runner_if.sv
// ALU drive/response bundle between the vector runner (master) and the ALU (slave).
interface alu_vector_runner_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_code;
  logic              mode_fp;
  logic              round_mode;
  logic              start;
  logic [DATA_W-1:0] result;
  logic              valid_out;
  logic [4:0]        flags;

  modport master (
    output op_a, op_b, op_code, mode_fp, round_mode, start,
    input  result, valid_out, flags
  );

  modport slave (
    input  op_a, op_b, op_code, mode_fp, round_mode, start,
    output result, valid_out, flags
  );
endinterface

// File: rtl/alu_vector_runner_table.sv
// Vector table for the runner: one synchronous write port, one combinational read port.
module alu_vec_table
  import alu_vec_pkg::*;
#(
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned IDX_W   = $clog2(NUM_VEC)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_addr,
  input  vec_entry_t       wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output vec_entry_t       rd_data
);

  vec_entry_t mem [NUM_VEC];

  // No reset: table contents survive rst so a run can be repeated.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_vector_runner.sv
// Vector sequencer/checker driving the IEEE-754 alu through its start/valid_out handshake.
// Optional first-failure response log enabled by defining ALU_VEC_FAILLOG_EN.
//
// state         | meaning
// IDLE          | accepts table writes and run
// ISSUE         | registers entry fields onto the ALU bus, raises start
// WAIT_VALID    | start held until valid_out, response captured
// CHECK         | start low, response compared, counters updated
// WAIT_CLEAR    | waits for valid_out low, then advances or finishes
// DONE          | one cycle; done rises, then back to IDLE
module alu_vector_runner
  import alu_vec_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_VEC     = 16,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned IDX_W       = $clog2(NUM_VEC),
  parameter int unsigned CNT_W       = $clog2(NUM_VEC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vec_we,
  input  logic [IDX_W-1:0]    vec_addr,
  input  logic [DATA_W-1:0]   vec_op_a,
  input  logic [DATA_W-1:0]   vec_op_b,
  input  logic [2:0]          vec_op_code,
  input  logic                vec_mode_fp,
  input  logic                vec_round_mode,
  input  logic [DATA_W-1:0]   vec_exp_result,
  input  logic [4:0]          vec_exp_flags,
  input  logic                run,
  input  logic [CNT_W-1:0]    num_vec,
  alu_vector_runner_if.master alu,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic [IDX_W-1:0]    first_fail_idx,
  output logic                any_fail,
  output logic [DATA_W-1:0]   fail_result,
  output logic [4:0]          fail_flags
);

  localparam int unsigned      TMR_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  vec_i_q;
  logic [CNT_W-1:0]  run_len_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [DATA_W-1:0] cap_result_q;
  logic [4:0]        cap_flags_q;

  vec_entry_t wr_entry, rd_entry;
  logic       tbl_we;
  logic       accept_run, tmo_hit, tmr_load, tmr_dec;
  logic       is_last, res_match, flg_match, pass_ev, fail_ev;

  always_comb begin
    wr_entry            = '0;
    wr_entry.op_a       = VEC_DATA_W'(vec_op_a);
    wr_entry.op_b       = VEC_DATA_W'(vec_op_b);
    wr_entry.op_code    = vec_op_code;
    wr_entry.mode_fp    = vec_mode_fp;
    wr_entry.round_mode = vec_round_mode;
    wr_entry.exp_result = VEC_DATA_W'(vec_exp_result);
    wr_entry.exp_flags  = vec_exp_flags;
  end

  assign tbl_we = vec_we && !busy;

  alu_vec_table #(
    .NUM_VEC (NUM_VEC),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk     (clk),
    .we      (tbl_we),
    .wr_addr (vec_addr),
    .wr_data (wr_entry),
    .rd_addr (vec_i_q[IDX_W-1:0]),
    .rd_data (rd_entry)
  );

  // Half-precision entries only own the low 16 result bits.
  assign res_match = rd_entry.mode_fp ? (cap_result_q == DATA_W'(rd_entry.exp_result))
                                      : (cap_result_q[15:0] == rd_entry.exp_result[15:0]);
  assign flg_match = (cap_flags_q == rd_entry.exp_flags);
  assign is_last   = ((vec_i_q + CNT_W'(1)) == run_len_q);

  always_comb begin
    state_d    = state_q;
    accept_run = 1'b0;
    tmo_hit    = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    pass_ev    = 1'b0;
    fail_ev    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          accept_run = 1'b1;
          state_d    = (num_vec == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_load = 1'b1;
        state_d  = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        if (alu.valid_out) begin
          state_d = ST_CHECK;
        end else if (tmr_q == '0) begin
          tmo_hit = 1'b1;
          fail_ev = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        tmr_load = 1'b1;
        pass_ev  = res_match && flg_match;
        fail_ev  = !(res_match && flg_match);
        state_d  = ST_WAIT_CLEAR;
      end
      ST_WAIT_CLEAR: begin
        if (!alu.valid_out) begin
          state_d = is_last ? ST_DONE : ST_ISSUE;
        end else if (tmr_q == '0) begin
          tmo_hit = 1'b1;
          fail_ev = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      vec_i_q        <= '0;
      run_len_q      <= '0;
      tmr_q          <= '0;
      cap_result_q   <= '0;
      cap_flags_q    <= '0;
      alu.op_a       <= '0;
      alu.op_b       <= '0;
      alu.op_code    <= '0;
      alu.mode_fp    <= 1'b0;
      alu.round_mode <= 1'b0;
      alu.start      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      any_fail       <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE) && (state_d != ST_DONE);

      if (accept_run) begin
        vec_i_q        <= '0;
        run_len_q      <= (num_vec > NUM_VEC_C) ? NUM_VEC_C : num_vec;
        done           <= 1'b0;
        timeout        <= 1'b0;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        first_fail_idx <= '0;
        any_fail       <= 1'b0;
      end

      if (state_q == ST_DONE) begin
        done <= 1'b1;
      end

      if (state_q == ST_ISSUE) begin
        alu.op_a       <= DATA_W'(rd_entry.op_a);
        alu.op_b       <= DATA_W'(rd_entry.op_b);
        alu.op_code    <= rd_entry.op_code;
        alu.mode_fp    <= rd_entry.mode_fp;
        alu.round_mode <= rd_entry.round_mode;
        alu.start      <= 1'b1;
      end

      if (state_q == ST_WAIT_VALID && alu.valid_out) begin
        cap_result_q <= alu.result;
        cap_flags_q  <= alu.flags;
      end

      if (state_q == ST_WAIT_VALID && (alu.valid_out || tmo_hit)) begin
        alu.start <= 1'b0;
      end

      if (tmr_load) begin
        tmr_q <= TMR_LOAD;
      end else if (tmr_dec) begin
        tmr_q <= tmr_q - TMR_W'(1);
      end

      if (state_q == ST_WAIT_CLEAR && !alu.valid_out) begin
        vec_i_q <= vec_i_q + CNT_W'(1);
      end

      if (tmo_hit) begin
        timeout <= 1'b1;
      end

      if (pass_ev && pass_cnt != CNT_MAX) begin
        pass_cnt <= pass_cnt + CNT_W'(1);
      end

      if (fail_ev) begin
        if (fail_cnt != CNT_MAX) begin
          fail_cnt <= fail_cnt + CNT_W'(1);
        end
        if (!any_fail) begin
          any_fail       <= 1'b1;
          first_fail_idx <= vec_i_q[IDX_W-1:0];
        end
      end
    end
  end

`ifdef ALU_VEC_FAILLOG_EN
  logic [DATA_W-1:0] flog_result_q;
  logic [4:0]        flog_flags_q;
  logic              log_ev;

  // Only a compare mismatch has a response worth logging; a timeout has none.
  assign log_ev = (state_q == ST_CHECK) && !(res_match && flg_match) && !any_fail;

  always_ff @(posedge clk) begin
    if (rst || accept_run) begin
      flog_result_q <= '0;
      flog_flags_q  <= '0;
    end else if (log_ev) begin
      flog_result_q <= cap_result_q;
      flog_flags_q  <= cap_flags_q;
    end
  end

  assign fail_result = flog_result_q;
  assign fail_flags  = flog_flags_q;
`else
  assign fail_result = '0;
  assign fail_flags  = '0;
`endif

endmodule

// File: tb/tb_alu_vector_runner.sv
// Self-checking bench for alu_vector_runner with a scripted-latency stub ALU.
module tb_alu_vector_runner;
  import alu_vec_pkg::*;

  localparam int DATA_W      = 32;
  localparam int NUM_VEC     = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam int IDX_W       = 4;
  localparam int CNT_W       = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vec_we = 1'b0;
  logic [IDX_W-1:0]  vec_addr = '0;
  logic [DATA_W-1:0] vec_op_a = '0, vec_op_b = '0, vec_exp_result = '0;
  logic [2:0]        vec_op_code = '0;
  logic              vec_mode_fp = 1'b0, vec_round_mode = 1'b0;
  logic [4:0]        vec_exp_flags = '0;
  logic              run = 1'b0;
  logic [CNT_W-1:0]  num_vec = '0;
  logic              busy, done, timeout, any_fail;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt;
  logic [IDX_W-1:0]  first_fail_idx;
  logic [DATA_W-1:0] fail_result;
  logic [4:0]        fail_flags;

  alu_vector_runner_if #(.DATA_W(DATA_W)) bus ();

  alu_vector_runner #(
    .DATA_W(DATA_W), .NUM_VEC(NUM_VEC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .vec_we(vec_we), .vec_addr(vec_addr), .vec_op_a(vec_op_a), .vec_op_b(vec_op_b),
    .vec_op_code(vec_op_code), .vec_mode_fp(vec_mode_fp), .vec_round_mode(vec_round_mode),
    .vec_exp_result(vec_exp_result), .vec_exp_flags(vec_exp_flags),
    .run(run), .num_vec(num_vec), .alu(bus),
    .busy(busy), .done(done), .timeout(timeout),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
    .any_fail(any_fail), .fail_result(fail_result), .fail_flags(fail_flags)
  );

  always #5 clk = ~clk;

  // Stub ALU: valid_out rises lat cycles after start, falls one cycle after start drops.
  int unsigned lat = 2;
  bit          hang = 1'b0;
  int unsigned run_base = 0;
  int unsigned hs_valid = 0, start_rises = 0, start_hi = 0, cyc = 0, cyc_hi = 0;
  int unsigned rise_t [256];
  logic        start_prev = 1'b0;
  logic [31:0] resp_r [NUM_VEC];
  logic [4:0]  resp_f [NUM_VEC];

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    start_prev <= bus.start;
    if (bus.start === 1'b1) start_hi <= start_hi + 1;
    if (bus.start === 1'b1 && start_prev !== 1'b1) begin
      if (start_rises < 256) rise_t[start_rises] <= cyc;
      start_rises <= start_rises + 1;
    end
    if (rst || bus.start !== 1'b1) begin
      bus.valid_out <= 1'b0;
      cyc_hi        <= 0;
      if (rst) begin
        bus.result <= '0;
        bus.flags  <= '0;
      end
    end else if (!bus.valid_out) begin
      if (!hang && cyc_hi + 1 >= lat) begin
        bus.valid_out <= 1'b1;
        bus.result    <= resp_r[(hs_valid - run_base) % NUM_VEC];
        bus.flags     <= resp_f[(hs_valid - run_base) % NUM_VEC];
        hs_valid      <= hs_valid + 1;
      end else begin
        cyc_hi <= cyc_hi + 1;
      end
    end
  end

  // Reference copy of the table and expected outcomes
  logic [31:0] tb_er [NUM_VEC];
  logic [4:0]  tb_ef [NUM_VEC];
  bit          tb_fp [NUM_VEC];
  int          e_pass, e_fail, e_ffi;
  bit          e_any;
  logic [31:0] e_fr;
  logic [4:0]  e_ff;
  int          n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int k, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                     input bit fp, input logic [31:0] er, input logic [4:0] ef,
                     input logic [31:0] rr, input logic [4:0] rf);
    tb_er[k] = er; tb_ef[k] = ef; tb_fp[k] = fp; resp_r[k] = rr; resp_f[k] = rf;
    vec_we = 1'b1; vec_addr = IDX_W'(k); vec_op_a = a; vec_op_b = b; vec_op_code = op;
    vec_mode_fp = fp; vec_round_mode = 1'b0; vec_exp_result = er; vec_exp_flags = ef;
    @(negedge clk);
    vec_we = 1'b0;
  endtask

  task automatic do_run(input int n);
    run_base = hs_valid;
    run = 1'b1; num_vec = CNT_W'(n);
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
  endtask

  task automatic model(input int n);
    int  m;
    bit  ok;
    m = (n > NUM_VEC) ? NUM_VEC : n;
    e_pass = 0; e_fail = 0; e_ffi = 0; e_any = 0; e_fr = '0; e_ff = '0;
    for (int k = 0; k < m; k++) begin
      if (tb_fp[k]) ok = (resp_r[k] == tb_er[k]);
      else          ok = (resp_r[k][15:0] == tb_er[k][15:0]);
      ok = ok && (resp_f[k] == tb_ef[k]);
      if (ok) e_pass++;
      else begin
        if (!e_any) begin
          e_any = 1'b1; e_ffi = k; e_fr = resp_r[k]; e_ff = resp_f[k];
        end
        e_fail++;
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, " pass_cnt"}, 32'(pass_cnt), 32'(e_pass));
    check({tag, " fail_cnt"}, 32'(fail_cnt), 32'(e_fail));
    check({tag, " any_fail"}, 32'(any_fail), 32'(e_any));
    check({tag, " first_fail_idx"}, 32'(first_fail_idx), 32'(e_ffi));
    check({tag, " timeout"}, 32'(timeout), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
`ifdef ALU_VEC_FAILLOG_EN
    check({tag, " fail_result"}, fail_result, e_fr);
    check({tag, " fail_flags"}, 32'(fail_flags), 32'(e_ff));
`else
    check({tag, " fail_result"}, fail_result, 32'd0);
    check({tag, " fail_flags"}, 32'(fail_flags), 32'd0);
`endif
  endtask

  initial begin
    int unsigned r0, h0, n;
    logic [31:0] er;
    logic [4:0]  ef;
    bit          fp;
    int          pick;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst timeout", 32'(timeout), 32'd0);
    check("rst pass_cnt", 32'(pass_cnt), 32'd0);
    check("rst fail_cnt", 32'(fail_cnt), 32'd0);
    check("rst any_fail", 32'(any_fail), 32'd0);
    check("rst first_fail_idx", 32'(first_fail_idx), 32'd0);
    check("rst alu_start", 32'(bus.start), 32'd0);
    check("rst alu_op_a", bus.op_a, 32'd0);
    check("rst fail_result", fail_result, 32'd0);

    // SP 5.0 / 2.0
    lat = 2;
    put(0, 32'h40A00000, 32'h40000000, OP_DIV, 1'b1, 32'h40200000, 5'd0, 32'h40200000, 5'd0);
    do_run(1);
    wait_done("sp_div");
    model(1);
    check_status("sp_div");
    check("sp_div pass_is_one", 32'(pass_cnt), 32'd1);

    // Mixed three-entry run, third expectation deliberately wrong
    lat = 3;
    put(0, 32'h3F800000, 32'h3F800000, OP_ADD, 1'b1, 32'h40000000, 5'd0, 32'h40000000, 5'd0);
    put(1, 32'h40400000, 32'h3F800000, OP_SUB, 1'b1, 32'h40000000, 5'd0, 32'h40000000, 5'd0);
    put(2, 32'h3F800000, 32'h40000000, OP_MUL, 1'b1, 32'h3F800000, 5'd0, 32'h40000000, 5'd0);
    r0 = start_rises;
    do_run(3);
    wait_done("mixed");
    model(3);
    check_status("mixed");
    check("mixed first_fail_is_2", 32'(first_fail_idx), 32'd2);
    check("mixed period01", rise_t[r0 + 1] - rise_t[r0], lat + 4);
    check("mixed period12", rise_t[r0 + 2] - rise_t[r0 + 1], lat + 4);

    // Half precision, written in the same cycle as run; upper bits ignored
    lat = 1;
    tb_er[0] = 32'hFFFF4000; tb_ef[0] = 5'd0; tb_fp[0] = 1'b0;
    resp_r[0] = 32'h00004000; resp_f[0] = 5'd0;
    run_base = hs_valid;
    vec_we = 1'b1; vec_addr = '0; vec_op_a = 32'h00003C00; vec_op_b = 32'h00003C00;
    vec_op_code = OP_ADD; vec_mode_fp = 1'b0; vec_exp_result = 32'hFFFF4000; vec_exp_flags = 5'd0;
    run = 1'b1; num_vec = CNT_W'(1);
    @(negedge clk);
    vec_we = 1'b0; run = 1'b0;
    wait_done("hp");
    model(1);
    check_status("hp");
    check("hp pass_is_one", 32'(pass_cnt), 32'd1);

    // Randomized full-table runs; last one over-asks and must clamp
    for (int rnd = 0; rnd < 4; rnd++) begin
      lat = $urandom_range(1, 5);
      for (int k = 0; k < NUM_VEC; k++) begin
        er = $urandom; ef = 5'($urandom_range(0, 31)); fp = 1'($urandom_range(0, 1));
        pick = $urandom_range(0, 3);
        case (pick)
          0: put(k, $urandom, $urandom, 3'($urandom_range(0, 3)), fp, er, ef, er, ef);
          1: put(k, $urandom, $urandom, 3'($urandom_range(0, 3)), fp, er, ef,
                 er ^ (32'd1 << $urandom_range(0, 15)), ef);
          2: put(k, $urandom, $urandom, 3'($urandom_range(0, 3)), fp, er, ef,
                 er, ef ^ 5'(1 << $urandom_range(0, 4)));
          default: put(k, $urandom, $urandom, 3'($urandom_range(0, 3)), fp, er, ef,
                       er ^ 32'hFFFF0000, ef);
        endcase
      end
      n = (rnd == 3) ? NUM_VEC + 5 : $urandom_range(1, NUM_VEC);
      h0 = hs_valid;
      do_run(int'(n));
      wait_done("rand");
      model(int'(n));
      check_status("rand");
      if (rnd == 3) check("clamp handshakes", hs_valid - h0, NUM_VEC);
    end

    // Zero-length run
    r0 = start_rises;
    do_run(0);
    check("zero done_at_1", 32'(done), 32'd0);
    @(negedge clk);
    check("zero done_at_2", 32'(done), 32'd1);
    check("zero no_start", start_rises - r0, 32'd0);
    check("zero pass_cnt", 32'(pass_cnt), 32'd0);
    check("zero fail_cnt", 32'(fail_cnt), 32'd0);

    // Stalled ALU
    hang = 1'b1;
    put(0, 32'h3F800000, 32'h3F800000, OP_ADD, 1'b1, 32'h40000000, 5'd0, 32'h40000000, 5'd0);
    h0 = start_hi;
    do_run(1);
    wait_done("tmo");
    check("tmo timeout", 32'(timeout), 32'd1);
    check("tmo fail_cnt", 32'(fail_cnt), 32'd1);
    check("tmo pass_cnt", 32'(pass_cnt), 32'd0);
    check("tmo any_fail", 32'(any_fail), 32'd1);
    check("tmo first_fail_idx", 32'(first_fail_idx), 32'd0);
    check("tmo start_cycles", start_hi - h0, TIMEOUT_CYC);
    check("tmo start_low", 32'(bus.start), 32'd0);
    hang = 1'b0;

    // Reset in the middle of WAIT_VALID, then rerun from the retained table
    lat = 10;
    do_run(1);
    @(negedge clk);
    @(negedge clk);
    check("midrst busy_before", 32'(busy), 32'd1);
    check("midrst start_before", 32'(bus.start), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst start", 32'(bus.start), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst timeout", 32'(timeout), 32'd0);
    check("midrst pass_cnt", 32'(pass_cnt), 32'd0);
    check("midrst fail_cnt", 32'(fail_cnt), 32'd0);
    check("midrst any_fail", 32'(any_fail), 32'd0);
    lat = 2;
    do_run(1);
    wait_done("rerun");
    model(1);
    check_status("rerun");
    check("rerun pass_is_one", 32'(pass_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
